dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder: the target end of the pipeline's load/store interface. It replaces the zero-latency data memory array with a handshaked, multi-cycle slave.
- Accepts one request at a time and inserts a configurable number of wait states. It then returns exactly one response per request, carrying read data or an error flag.
- Sits behind the MEM stage. The pipeline holds its request stable and stalls until resp_valid.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words in storage (power of two, 4..65536)
WAIT_STATES, 2, cycles spent in WAIT between acceptance and response (0..15)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset (reset==0 on a rising edge resets the block)
req_valid  input  1  request present
req_write  input  1  1=store, 0=load
req_addr  input  32  byte address
req_wdata  input  32  store data
req_ready  output  1  responder can accept a request this cycle
resp_valid  output  1  response valid, single-cycle pulse
resp_rdata  output  32  load data; 0 for stores and errors
resp_err  output  1  misaligned or out-of-range access

Behaviour:
- Reset (reset==0 at a rising edge):
  - state=IDLE, wait counter=0, latched request cleared.
  - resp_valid=0, resp_rdata=0, resp_err=0.
  - req_ready=1 once in IDLE (req_ready = state==IDLE).
  - Storage contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Acceptance happens at the edge where req_valid && req_ready.
  - On acceptance, latch req_write, req_addr, req_wdata and load the counter with WAIT_STATES.
  - Next state is WAIT if WAIT_STATES>0, else RESP.
- WAIT:
  - req_ready=0; the counter decrements each cycle.
  - Go to RESP at the edge where the counter==1.
  - Duration is exactly WAIT_STATES cycles.
- Entering RESP (the same edge):
  - Error check: err = (addr[1:0]!=0) || (addr[31:2] >= DEPTH_WORDS).
  - If !err and store: write wdata to word addr[31:2]. Stores never modify storage when err=1.
  - If !err and load: resp_rdata <= word addr[31:2]. Otherwise resp_rdata <= 0.
  - resp_err <= err.
- RESP:
  - resp_valid=1 for exactly one cycle; req_ready=0.
  - Unconditionally return to IDLE next edge; there is no response backpressure.
  - resp_rdata and resp_err return to 0 when leaving RESP.
- Latency: request accepted at edge E, resp_valid high in the cycle after edge E+WAIT_STATES. Minimum issue interval is WAIT_STATES+2 cycles.
- req_valid while req_ready=0 is ignored and not queued. The requester must hold the request until acceptance.
- Back-to-back: a request present in the RESP cycle is accepted on the first IDLE cycle after RESP.
- Read-after-write to the same address returns the new data, since the write is committed before the later request is accepted.
- Reset mid-operation:
  - In WAIT, the transaction is abandoned with no write and no response.
  - In RESP, a write already committed stays committed and the response is dropped.

Optional Feature:
- Macro: DMEM_BYTE_EN_EN.
- Defined:
  - Adds input req_be[3:0], latched at acceptance.
  - Stores write only the byte lanes whose bit is set; lane0 = bits 7:0.
  - Loads ignore req_be and return the full word.
  - req_be==0 on a store completes with resp_err=0 and no change to storage.
- Undefined:
  - Port absent; every store writes all 4 bytes.

Decomposition:
- Shared package dmem_pkg holds:
  - state encoding constants (IDLE=2'd0, WAIT=2'd1, RESP=2'd2)
  - word width (32) and byte-lane count (4)
  - counter width (4)
- Sub-module dmem_array:
  - synchronous single-port storage of DEPTH_WORDS x 32
  - ports: clk, we, be[3:0], word index, wdata, rdata
  - read data registered
  - instantiated once; the FSM and error check stay in dmem_responder.

Test Plan:
All scenarios use WAIT_STATES=2, DEPTH_WORDS=256.
1. Store 0xDEADBEEF at 0x10, then load 0x10 -> store: resp_valid 3 cycles after acceptance, rdata=0, err=0; load: rdata=0xDEADBEEF, err=0.
2. Load 0x12 (misaligned) and store 0x400 (out of range) -> both give resp_err=1, rdata=0; a follow-up load of 0x0 is unchanged.
3. Hold req_valid continuously with new requests -> req_ready low in WAIT/RESP; accepts spaced exactly 4 cycles apart; one resp_valid pulse per accept.
4. Store 0x11111111 to 0x20, assert reset==0 in the second WAIT cycle, then load 0x20 -> no response for the aborted store; load returns the prior contents.
5. With DMEM_BYTE_EN_EN: word 0x30=0xAABBCCDD, store 0x00000011 with be=4'b0001 -> load returns 0xAABBCC11; a store with be=0 leaves 0xAABBCC11.
6. WAIT_STATES=0 build: load accepted at edge E -> resp_valid in the cycle after E; issue interval 2 cycles.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
//   - FSM state encoding (StIdle, StWait, StResp)
//   - word width, byte-lane count and wait-counter width
package dmem_pkg;

  localparam int unsigned WordWidth = 32;
  localparam int unsigned NumLanes  = 4;
  localparam int unsigned CntWidth  = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port word storage with per-byte write enables.
// Ports:
//   clk    - clock, rising edge
//   we     - write enable
//   be     - byte-lane enables for writes (lane 0 = bits 7:0)
//   idx    - word index
//   wdata  - write data
//   rdata  - registered read data (value before any same-edge write)
// No reset: contents persist across resets.
module dmem_array import dmem_pkg::*; #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned IdxWidth    = $clog2(DEPTH_WORDS)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [NumLanes-1:0]  be,
  input  logic [IdxWidth-1:0]  idx,
  input  logic [WordWidth-1:0] wdata,
  output logic [WordWidth-1:0] rdata
);

  logic [WordWidth-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NumLanes; i++) begin
        if (be[i]) begin
          mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
    rdata <= mem[idx];
  end

endmodule

// File: rtl/dmem_responder.sv
// Handshaked multi-cycle data-memory slave for the pipeline's load/store port.
// Accepts one request at a time, spends WAIT_STATES cycles waiting, then pulses
// resp_valid for one cycle with load data or an error flag.
// Ports:
//   clk, reset          - clock; synchronous active-low reset
//   req_valid/req_ready - request handshake (ready only in idle)
//   req_write           - 1 = store, 0 = load
//   req_addr, req_wdata - byte address and store data
//   req_be              - store byte enables (only with DMEM_BYTE_EN_EN)
//   resp_valid          - single-cycle response pulse
//   resp_rdata          - load data; 0 for stores and errors
//   resp_err            - misaligned or out-of-range access
// Build option: define DMEM_BYTE_EN_EN to add req_be byte-lane store masking.
module dmem_responder import dmem_pkg::*; #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  input  logic                 req_write,
  input  logic [WordWidth-1:0] req_addr,
  input  logic [WordWidth-1:0] req_wdata,
`ifdef DMEM_BYTE_EN_EN
  input  logic [NumLanes-1:0]  req_be,
`endif
  output logic                 req_ready,
  output logic                 resp_valid,
  output logic [WordWidth-1:0] resp_rdata,
  output logic                 resp_err
);

  localparam int unsigned IdxWidth = $clog2(DEPTH_WORDS);
  localparam logic [CntWidth-1:0] WaitCnt = CntWidth'(WAIT_STATES);

  state_e               state_q, state_d;
  logic [CntWidth-1:0]  cnt_q, cnt_d;
  logic                 write_q;
  logic [WordWidth-1:0] addr_q;
  logic [WordWidth-1:0] wdata_q;
  logic                 err_q;
  logic                 rd_sel_q;

  logic                 accept;
  logic                 enter_resp;
  logic                 cur_write;
  logic [WordWidth-1:0] cur_addr;
  logic [WordWidth-1:0] cur_wdata;
  logic [NumLanes-1:0]  cur_be;
  logic                 cur_err;
  logic                 arr_we;
  logic [WordWidth-1:0] arr_rdata;

  assign accept     = (state_q == StIdle) && req_valid;
  assign enter_resp = (state_d == StResp) && (state_q != StResp);

  // With zero wait states the response is resolved on the acceptance edge,
  // before the request has been latched, so select the live inputs in idle.
  assign cur_write = (state_q == StIdle) ? req_write : write_q;
  assign cur_addr  = (state_q == StIdle) ? req_addr  : addr_q;
  assign cur_wdata = (state_q == StIdle) ? req_wdata : wdata_q;

`ifdef DMEM_BYTE_EN_EN
  logic [NumLanes-1:0] be_q;
  assign cur_be = (state_q == StIdle) ? req_be : be_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      be_q <= '0;
    end else if (accept) begin
      be_q <= req_be;
    end
  end
`else
  assign cur_be = '1;
`endif

  assign cur_err = (cur_addr[1:0] != 2'b00) ||
                   ({2'b00, cur_addr[WordWidth-1:2]} >= DEPTH_WORDS);

  // A reset on the resolving edge abandons the transaction, including its write.
  assign arr_we = enter_resp && reset && cur_write && !cur_err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d = (WAIT_STATES == 0) ? StResp : StWait;
          cnt_d   = WaitCnt;
        end
      end
      StWait: begin
        cnt_d = cnt_q - CntWidth'(1);
        if (cnt_q == CntWidth'(1)) begin
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      rd_sel_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        write_q <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      // Both flags are only ever set for the single RESP cycle.
      if (enter_resp) begin
        err_q    <= cur_err;
        rd_sel_q <= !cur_err && !cur_write;
      end else begin
        err_q    <= 1'b0;
        rd_sel_q <= 1'b0;
      end
    end
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IdxWidth    (IdxWidth)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .be    (cur_be),
    .idx   (cur_addr[IdxWidth+1:2]),
    .wdata (cur_wdata),
    .rdata (arr_rdata)
  );

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_err   = err_q;
  assign resp_rdata = rd_sel_q ? arr_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: behavioural reference model plus per-cycle compare,
// directed scenarios with literal expectations, and randomized traffic.
module tb_dmem_responder;

  localparam int unsigned Depth = 256;
  localparam int unsigned W     = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = 4'hF;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Model outputs for the current cycle
  logic        exp_ready = 1'b1;
  logic        exp_valid = 1'b0;
  logic        exp_err   = 1'b0;
  logic [31:0] exp_rdata = '0;

  dmem_responder #(
    .DEPTH_WORDS (Depth),
    .WAIT_STATES (W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
`ifdef DMEM_BYTE_EN_EN
    .req_be     (req_be),
`endif
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  // Reference model: a request occupies the port for W+1 cycles after its
  // acceptance edge; the last of those is the response cycle. The write is
  // committed on the edge that starts the response cycle. The default build
  // always drives req_be=4'hF, so all-lane stores fall out naturally.
  always @(posedge clk) begin : model
    int          left;
    logic        pw;
    logic [31:0] pa;
    logic [31:0] pd;
    logic [3:0]  pb;
    logic        err;
    logic [31:0] wi;
    logic [31:0] mem_m [Depth];
    if (!reset) begin
      left = 0;
      exp_valid <= 1'b0;
      exp_err   <= 1'b0;
      exp_rdata <= '0;
    end else begin
      exp_valid <= 1'b0;
      exp_err   <= 1'b0;
      exp_rdata <= '0;
      if (left > 0) begin
        left = left - 1;
      end else if (req_valid) begin
        pw = req_write;
        pa = req_addr;
        pd = req_wdata;
        pb = req_be;
        left = W + 1;
      end
      if (left == 1) begin
        err = (pa[1:0] != 2'b00) || ((pa >> 2) >= Depth);
        wi  = pa >> 2;
        exp_valid <= 1'b1;
        exp_err   <= err;
        if (!err && pw) begin
          for (int l = 0; l < 4; l++) begin
            if (pb[l]) mem_m[wi][8*l +: 8] = pd[8*l +: 8];
          end
        end
        exp_rdata <= (!err && !pw) ? mem_m[wi] : 32'h0;
      end
    end
    exp_ready <= (left == 0);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_checks += 4;
      if (req_ready !== exp_ready) begin
        n_fail++;
        $display("FAIL cyc_ready @%0t: got %b expected %b", $time, req_ready, exp_ready);
      end
      if (resp_valid !== exp_valid) begin
        n_fail++;
        $display("FAIL cyc_valid @%0t: got %b expected %b", $time, resp_valid, exp_valid);
      end
      if (resp_err !== exp_err) begin
        n_fail++;
        $display("FAIL cyc_err @%0t: got %b expected %b", $time, resp_err, exp_err);
      end
      if (resp_rdata !== exp_rdata) begin
        n_fail++;
        $display("FAIL cyc_rdata @%0t: got 0x%08h expected 0x%08h", $time, resp_rdata,
                 exp_rdata);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called just after a rising edge; returns once the coming edge will accept.
  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: got req_ready=0 expected 1 within 50 cycles");
    end
  endtask

  task automatic xact(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] be, output int lat, output logic [31:0] rd,
                      output logic er);
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    req_be    = be;
    wait_ready();
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_wdata = $urandom;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 20);
    if (!resp_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL resp_timeout: got no resp_valid expected one within 20 cycles");
    end
    rd = resp_rdata;
    er = resp_err;
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r = $urandom_range(0, 9);
    logic [7:0] w = 8'($urandom_range(0, 255));
    if (r < 7) return {22'b0, w, 2'b00};
    if (r == 7) return {22'b0, w, 2'($urandom_range(1, 3))};
    if (r == 8) return 32'h400 + (32'($urandom_range(0, 1023)) << 2);
    return ($urandom & ~32'h3) | 32'h8000_0000;
  endfunction

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got no end of test expected $finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int          lat;
    logic [31:0] rd;
    logic        er;
    longint      t_prev;
    longint      t_now;
    int          cnt;

    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_ready", 32'(req_ready), 32'd1);
    check("reset_valid", 32'(resp_valid), 32'd0);
    check("reset_rdata", resp_rdata, 32'h0);
    check("reset_err", 32'(resp_err), 32'd0);

    // Fill storage so every later load has a defined expectation.
    for (int i = 0; i < Depth; i++) begin
      xact(1'b1, 32'(i) << 2, $urandom, 4'hF, lat, rd, er);
    end

    // Store then load the same word.
    xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, rd, er);
    check("st_latency", 32'(lat), 32'd3);
    check("st_rdata", rd, 32'h0);
    check("st_err", 32'(er), 32'd0);
    xact(1'b0, 32'h10, 32'h0, 4'hF, lat, rd, er);
    check("ld_latency", 32'(lat), 32'd3);
    check("ld_rdata", rd, 32'hDEADBEEF);
    check("ld_err", 32'(er), 32'd0);

    // Error cases; the out-of-range store must not alias onto word 0.
    xact(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, lat, rd, er);
    xact(1'b0, 32'h12, 32'h0, 4'hF, lat, rd, er);
    check("misalign_err", 32'(er), 32'd1);
    check("misalign_rdata", rd, 32'h0);
    xact(1'b1, 32'h400, 32'hBAD0BAD0, 4'hF, lat, rd, er);
    check("range_err", 32'(er), 32'd1);
    check("range_rdata", rd, 32'h0);
    xact(1'b0, 32'h0, 32'h0, 4'hF, lat, rd, er);
    check("word0_unchanged", rd, 32'hCAFEF00D);
    check("word0_err", 32'(er), 32'd0);

    // Continuously valid requests: accepts spaced W+2 cycles apart.
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_write = 1'($urandom);
    req_addr  = rand_addr();
    req_wdata = $urandom;
    t_prev = 0;
    for (int k = 0; k < 12; k++) begin
      wait_ready();
      @(posedge clk);
      t_now = $time;
      if (k > 0) check("accept_spacing", 32'((t_now - t_prev) / 10), 32'(W + 2));
      t_prev = t_now;
      #1;
      req_write = 1'($urandom);
      req_addr  = rand_addr();
      req_wdata = $urandom;
    end
    req_valid = 1'b0;
    repeat (W + 2) @(posedge clk);

    // Reset during the second wait cycle abandons the store and its response.
    xact(1'b1, 32'h20, 32'h55AA55AA, 4'hF, lat, rd, er);
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'h11111111;
    req_be    = 4'hF;
    wait_ready();
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid) cnt++;
    end
    check("abort_no_resp", 32'(cnt), 32'd0);
    xact(1'b0, 32'h20, 32'h0, 4'hF, lat, rd, er);
    check("abort_no_write", rd, 32'h55AA55AA);

`ifdef DMEM_BYTE_EN_EN
    xact(1'b1, 32'h30, 32'hAABBCCDD, 4'hF, lat, rd, er);
    xact(1'b1, 32'h30, 32'h00000011, 4'b0001, lat, rd, er);
    xact(1'b0, 32'h30, 32'h0, 4'b0000, lat, rd, er);
    check("be_lane0", rd, 32'hAABBCC11);
    xact(1'b1, 32'h30, 32'hFFFFFFFF, 4'b0000, lat, rd, er);
    check("be_zero_err", 32'(er), 32'd0);
    xact(1'b0, 32'h30, 32'h0, 4'hF, lat, rd, er);
    check("be_zero_nochange", rd, 32'hAABBCC11);
`endif

    // Randomized traffic; the per-cycle compare carries the checking.
    for (int i = 0; i < 400; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
`ifdef DMEM_BYTE_EN_EN
      xact(1'($urandom), rand_addr(), $urandom, 4'($urandom), lat, rd, er);
`else
      xact(1'($urandom), rand_addr(), $urandom, 4'hF, lat, rd, er);
`endif
      check("rand_latency", 32'(lat), 32'(W + 1));
    end

    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
